// File: rtl/mvu_pkg.sv
// Shared MVU types and sizes for the array and its job scheduler.
package mvu_pkg;

   localparam int NMVU     = 8;
   localparam int BCNTDWN  = 8;
   localparam int BMVUID   = $clog2(NMVU);
   localparam int MVU_BTAG = 4;

   typedef struct packed {
      logic [BMVUID-1:0]   mvuid;
      logic [BCNTDWN-1:0]  countdown;
      logic [MVU_BTAG-1:0] tag;
   } mvu_job_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CPL  = 2'd2
   } mvu_sched_state_e;

endpackage

// File: rtl/mvu_job_fifo.sv
// Synchronous job-descriptor FIFO; power-of-2 depth, full/empty/count flags.
module mvu_job_fifo
   import mvu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int BA    = $clog2(DEPTH),
   localparam int BC    = BA + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  mvu_job_t      din,
   output mvu_job_t      dout,
   output logic          full,
   output logic          empty,
   output logic [BC-1:0] count
);

   mvu_job_t      mem [DEPTH];
   logic [BA-1:0] wr_ptr;
   logic [BA-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == BC'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mvu_job_scheduler.sv
// In-order MVU job dispatcher with round-robin tagged completion return.
// Optional per-MVU watchdog enabled by defining MVU_SCHED_WDOG_EN.
//
// state | meaning
// IDLE  | MVU free, may take the queue head
// RUN   | job started, waiting for done (or watchdog expiry)
// CPL   | completion pending on the host channel
module mvu_job_scheduler
   import mvu_pkg::*;
#(
   parameter int NMVU        = mvu_pkg::NMVU,
   parameter int BCNTDWN     = mvu_pkg::BCNTDWN,
   parameter int QDEPTH      = 4,
   parameter int BTAG        = 4,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [$clog2(NMVU)-1:0]   job_mvu,
   input  logic [BCNTDWN-1:0]        job_countdown,
   input  logic [BTAG-1:0]           job_tag,
   output logic [NMVU-1:0]           start,
   output logic [NMVU*BCNTDWN-1:0]   countdown,
   input  logic [NMVU-1:0]           done,
   output logic [NMVU-1:0]           busy,
   output logic                      cpl_valid,
   input  logic                      cpl_ready,
   output logic [$clog2(NMVU)-1:0]   cpl_mvu,
   output logic [BTAG-1:0]           cpl_tag,
   output logic                      cpl_err,
   output logic [$clog2(QDEPTH):0]   qcount
);

   localparam int BID = $clog2(NMVU);

   mvu_job_t           job_in;
   mvu_job_t           head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               dispatch;

   mvu_sched_state_e   state_q [NMVU];
   mvu_sched_state_e   state_d [NMVU];
   logic [BCNTDWN-1:0] cntdwn_q [NMVU];
   logic [BTAG-1:0]    tag_q [NMVU];
   logic [NMVU-1:0]    cpl_pend;
   logic [NMVU-1:0]    timeout;

   logic [BID-1:0]     last_grant_q;
   logic [BID-1:0]     lock_mvu_q;
   logic               lock_vld_q;
   logic [BID-1:0]     rr_mvu;
   logic               rr_hit;
   int                 rr_idx;
   logic [BID-1:0]     grant;
   logic               cpl_hs;

   assign job_in = '{mvuid: job_mvu, countdown: job_countdown, tag: job_tag};

   mvu_job_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (job_valid),
      .pop   (dispatch),
      .din   (job_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (qcount)
   );

   assign job_ready = !fifo_full;
   assign dispatch  = !fifo_empty && (state_q[head.mvuid] == IDLE);

   // Countdown bypasses the register during the start cycle so it is valid alongside start.
   always_comb begin
      start     = '0;
      countdown = '0;
      if (dispatch) start[head.mvuid] = 1'b1;
      for (int i = 0; i < NMVU; i++) begin
         busy[i]     = (state_q[i] != IDLE);
         cpl_pend[i] = (state_q[i] == CPL);
         countdown[i*BCNTDWN +: BCNTDWN] = start[i] ? head.countdown : cntdwn_q[i];
      end
   end

   always_comb begin
      rr_mvu = '0;
      rr_hit = 1'b0;
      rr_idx = 0;
      for (int k = 1; k <= NMVU; k++) begin
         rr_idx = (int'(last_grant_q) + k) % NMVU;
         if (!rr_hit && cpl_pend[rr_idx]) begin
            rr_hit = 1'b1;
            rr_mvu = BID'(rr_idx);
         end
      end
   end

   // A presented completion is locked so later arrivals cannot displace it.
   assign grant     = lock_vld_q ? lock_mvu_q : rr_mvu;
   assign cpl_valid = |cpl_pend;
   assign cpl_hs    = cpl_valid && cpl_ready;
   assign cpl_mvu   = cpl_valid ? grant : '0;
   assign cpl_tag   = cpl_valid ? tag_q[grant] : '0;

   always_comb begin
      for (int i = 0; i < NMVU; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            IDLE:    if (start[i]) state_d[i] = RUN;
            RUN:     if (done[i] || timeout[i]) state_d[i] = CPL;
            CPL:     if (cpl_hs && (grant == BID'(i))) state_d[i] = IDLE;
            default: state_d[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NMVU; i++) begin
            state_q[i]  <= IDLE;
            cntdwn_q[i] <= '0;
            tag_q[i]    <= '0;
         end
         last_grant_q <= BID'(NMVU - 1);
         lock_vld_q   <= 1'b0;
         lock_mvu_q   <= '0;
      end else begin
         for (int i = 0; i < NMVU; i++) begin
            state_q[i] <= state_d[i];
            if (start[i]) begin
               cntdwn_q[i] <= head.countdown;
               tag_q[i]    <= head.tag;
            end
         end
         if (cpl_hs) begin
            last_grant_q <= grant;
            lock_vld_q   <= 1'b0;
         end else if (cpl_valid) begin
            lock_vld_q <= 1'b1;
            lock_mvu_q <= grant;
         end
      end
   end

`ifdef MVU_SCHED_WDOG_EN
   logic [16:0]     wdog_q [NMVU];
   logic [NMVU-1:0] err_q;

   // done in the expiry cycle wins, so the job completes without error.
   always_comb begin
      timeout = '0;
      for (int i = 0; i < NMVU; i++)
         timeout[i] = (state_q[i] == RUN) && !done[i] && (wdog_q[i] == 17'(WDOG_CYCLES - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NMVU; i++) wdog_q[i] <= '0;
         err_q <= '0;
      end else begin
         for (int i = 0; i < NMVU; i++) begin
            if (start[i]) begin
               wdog_q[i] <= '0;
               err_q[i]  <= 1'b0;
            end else if (state_q[i] == RUN) begin
               wdog_q[i] <= wdog_q[i] + 17'd1;
               if (timeout[i]) err_q[i] <= 1'b1;
            end
         end
      end
   end

   assign cpl_err = cpl_valid && err_q[grant];
`else
   logic unused_wdog;
   assign unused_wdog = (WDOG_CYCLES == 0);
   assign timeout     = '0;
   assign cpl_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mvu_job_scheduler.sv
// Scoreboard bench for mvu_job_scheduler: start and completion streams checked against queues.
module tb_mvu_job_scheduler;
   import mvu_pkg::*;

   localparam int NM = 8;
   localparam int BC = 8;
   localparam int QD = 4;
   localparam int BT = 4;
`ifdef MVU_SCHED_WDOG_EN
   localparam int WDOG = 50;
`else
   localparam int WDOG = 65535;
`endif

   logic                   clk;
   logic                   rst_n;
   logic                   job_valid;
   logic                   job_ready;
   logic [BMVUID-1:0]      job_mvu;
   logic [BC-1:0]          job_countdown;
   logic [BT-1:0]          job_tag;
   logic [NM-1:0]          start;
   logic [NM*BC-1:0]       countdown;
   logic [NM-1:0]          done;
   logic [NM-1:0]          busy;
   logic                   cpl_valid;
   logic                   cpl_ready;
   logic [BMVUID-1:0]      cpl_mvu;
   logic [BT-1:0]          cpl_tag;
   logic                   cpl_err;
   logic [$clog2(QD):0]    qcount;

   mvu_job_scheduler #(
      .NMVU(NM), .BCNTDWN(BC), .QDEPTH(QD), .BTAG(BT), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_mvu(job_mvu),
      .job_countdown(job_countdown), .job_tag(job_tag),
      .start(start), .countdown(countdown), .done(done), .busy(busy),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_mvu(cpl_mvu),
      .cpl_tag(cpl_tag), .cpl_err(cpl_err), .qcount(qcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int mvu;
      int cd;
      int tag;
      int err;
   } exp_t;

   exp_t exp_start[$];
   exp_t exp_cpl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_cpl_push(input int m, input int t, input int e);
      exp_t x;
      x.mvu = m; x.cd = 0; x.tag = t; x.err = e;
      exp_cpl.push_back(x);
   endtask

   task automatic push_job(input int m, input int cd, input int t);
      int   n;
      exp_t x;
      n = 0;
      job_valid     = 1'b1;
      job_mvu       = BMVUID'(m);
      job_countdown = BC'(cd);
      job_tag       = BT'(t);
      @(negedge clk);
      while (!job_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_wait", {31'd0, job_ready}, 32'd1);
      x.mvu = m; x.cd = cd; x.tag = t; x.err = 0;
      exp_start.push_back(x);
      @(posedge clk);
      #1;
      job_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      cpl_ready = 1'b1;
      while (exp_cpl.size() > 0 && n < 200) begin
         step();
         n++;
      end
      cpl_ready = 1'b0;
      chk({tag, "_drain"}, exp_cpl.size(), 0);
   endtask

   // Monitor: start pulses and completion handshakes against the scoreboards.
   exp_t        mon_e;
   logic        prev_stall;
   logic [31:0] prev_cpl;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (start != '0) begin
            chk("start_onehot", $countones(start), 1);
            for (int i = 0; i < NM; i++) begin
               if (start[i]) begin
                  if (exp_start.size() == 0) begin
                     chk("start_unexpected", {31'd0, start[i]}, 32'd0);
                  end else begin
                     mon_e = exp_start.pop_front();
                     chk("start_mvu", i, mon_e.mvu);
                     chk("start_cd", countdown[i*BC +: BC], mon_e.cd);
                  end
               end
            end
         end
         if (prev_stall)
            chk("cpl_hold", {23'd0, cpl_valid, cpl_err, cpl_mvu, cpl_tag}, prev_cpl);
         if (cpl_valid && cpl_ready) begin
            if (exp_cpl.size() == 0) begin
               chk("cpl_unexpected", {31'd0, cpl_valid}, 32'd0);
            end else begin
               mon_e = exp_cpl.pop_front();
               chk("cpl_mvu", cpl_mvu, mon_e.mvu);
               chk("cpl_tag", cpl_tag, mon_e.tag);
               chk("cpl_err", cpl_err, mon_e.err);
            end
         end
         prev_stall = cpl_valid && !cpl_ready;
         prev_cpl   = {23'd0, cpl_valid, cpl_err, cpl_mvu, cpl_tag};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0; job_valid = 1'b0; job_mvu = '0; job_countdown = '0;
      job_tag = '0; done = '0; cpl_ready = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cpl_valid", cpl_valid, 0);
      chk("rst_qcount", qcount, 0);
      chk("rst_job_ready", job_ready, 1);
      chk("rst_countdown", countdown[31:0] | countdown[63:32], 0);
      step();
      rst_n = 1'b1;
      step();

      // single job
      push_job(3, 100, 5);
      @(negedge clk);
      chk("t1_start", start, 8'h08);
      chk("t1_cd", countdown[3*BC +: BC], 100);
      step();
      @(negedge clk);
      chk("t1_start_pulse", start, 0);
      chk("t1_busy", busy, 8'h08);
      chk("t1_cd_hold", countdown[3*BC +: BC], 100);
      repeat (3) step();
      exp_cpl_push(3, 5, 0);
      done = 8'h08;
      @(negedge clk);
      chk("t1_no_early_cpl", cpl_valid, 0);
      step();
      done = '0;
      @(negedge clk);
      chk("t1_cpl_valid", cpl_valid, 1);
      chk("t1_cpl_mvu", cpl_mvu, 3);
      chk("t1_cpl_tag", cpl_tag, 5);
      chk("t1_cpl_err", cpl_err, 0);
      step();
      drain("t1");
      @(negedge clk);
      chk("t1_busy_clr", busy, 0);

      // head-of-line blocking
      step();
      push_job(1, 10, 1);
      push_job(1, 11, 2);
      push_job(2, 12, 3);
      repeat (4) step();
      @(negedge clk);
      chk("hol_busy", busy, 8'h02);
      chk("hol_qcount", qcount, 2);
      step();
      exp_cpl_push(1, 1, 0);
      done = 8'h02;
      step();
      done = '0;
      cpl_ready = 1'b1;
      step();
      cpl_ready = 1'b0;
      @(negedge clk);
      chk("hol_start1", start, 8'h02);
      step();
      @(negedge clk);
      chk("hol_start2", start, 8'h04);
      step();
      step();
      exp_cpl_push(2, 3, 0);
      exp_cpl_push(1, 2, 0);
      done = 8'h06;
      step();
      done = '0;
      drain("hol");

      // queue full
      step();
      push_job(0, 20, 6);
      for (int t = 7; t <= 10; t++) push_job(0, 14 + t, t);
      @(negedge clk);
      chk("qf_count", qcount, 4);
      chk("qf_ready", job_ready, 0);
      step();
      job_valid = 1'b1; job_mvu = 3'd0; job_countdown = 8'd25; job_tag = 4'd11;
      begin
         exp_t x;
         x.mvu = 0; x.cd = 25; x.tag = 11; x.err = 0;
         exp_start.push_back(x);
      end
      repeat (3) begin
         @(negedge clk);
         chk("qf_hold", qcount, 4);
         step();
      end
      exp_cpl_push(0, 6, 0);
      done = 8'h01;
      step();
      done = '0;
      cpl_ready = 1'b1;
      step();
      cpl_ready = 1'b0;
      @(negedge clk);
      chk("qf_no_pushthru", job_ready, 0);
      n = 0;
      while (!job_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("qf_ready_again", job_ready, 1);
      @(posedge clk);
      #1;
      job_valid = 1'b0;
      @(negedge clk);
      chk("qf_count2", qcount, 4);
      step();
      for (int t = 7; t <= 11; t++) begin
         exp_cpl_push(0, t, 0);
         done = 8'h01;
         step();
         done = '0;
         cpl_ready = 1'b1;
         step();
         cpl_ready = 1'b0;
         step();
      end
      @(negedge clk);
      chk("qf_empty", qcount, 0);
      chk("qf_all_cpl", exp_cpl.size(), 0);

      // reset mid-run
      step();
      push_job(4, 40, 12);
      push_job(4, 41, 13);
      push_job(4, 42, 14);
      step();
      @(negedge clk);
      chk("rm_qcount", qcount, 2);
      chk("rm_busy", busy, 8'h10);
      step();
      rst_n = 1'b0;
      #2;
      chk("rm_start", start, 0);
      chk("rm_busy0", busy, 0);
      chk("rm_cpl_valid", cpl_valid, 0);
      chk("rm_qcount0", qcount, 0);
      chk("rm_job_ready", job_ready, 1);
      chk("rm_countdown", countdown[31:0] | countdown[63:32], 0);
      chk("rm_cpl_fields", {cpl_mvu, cpl_tag, cpl_err}, 0);
      exp_start.delete();
      exp_cpl.delete();
      step();
      step();
      rst_n = 1'b1;
      step();
      done = 8'h10;
      step();
      done = '0;
      repeat (3) begin
         @(negedge clk);
         chk("rm_late_done", cpl_valid, 0);
         step();
      end

      // round-robin
      push_job(0, 50, 1);
      push_job(2, 52, 2);
      push_job(5, 55, 3);
      step();
      step();
      exp_cpl_push(0, 1, 0);
      exp_cpl_push(2, 2, 0);
      exp_cpl_push(5, 3, 0);
      done = 8'h25;
      step();
      done = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rr_first", cpl_mvu, 0);
      step();
      drain("rr1");
      push_job(5, 56, 4);
      push_job(0, 57, 5);
      step();
      step();
      exp_cpl_push(0, 5, 0);
      exp_cpl_push(5, 4, 0);
      done = 8'h21;
      step();
      done = '0;
      step();
      drain("rr2");

      // done on one MVU in the same cycle as another's handshake
      push_job(2, 60, 6);
      push_job(3, 61, 7);
      step();
      step();
      exp_cpl_push(2, 6, 0);
      done = 8'h04;
      step();
      exp_cpl_push(3, 7, 0);
      done = 8'h08;
      cpl_ready = 1'b1;
      step();
      done = '0;
      cpl_ready = 1'b0;
      @(negedge clk);
      chk("sim_cpl3", {cpl_valid, cpl_mvu}, {1'b1, 3'd3});
      step();
      drain("sim");

`ifdef MVU_SCHED_WDOG_EN
      step();
      push_job(6, 66, 9);
      @(negedge clk);
      chk("wd_start", start, 8'h40);
      n = 0;
      while (!cpl_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wd_latency", n, 51);
      chk("wd_err", cpl_err, 1);
      exp_cpl_push(6, 9, 1);
      step();
      done = 8'h40;
      step();
      done = '0;
      @(negedge clk);
      chk("wd_late_done", {cpl_valid, cpl_err, cpl_mvu}, {1'b1, 1'b1, 3'd6});
      step();
      drain("wd");
`endif

      step();
      @(negedge clk);
      chk("end_start_sb", exp_start.size(), 0);
      chk("end_cpl_sb", exp_cpl.size(), 0);
      chk("end_busy", busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
